// File: rtl/cam_word_ctrl.sv
// cam_word_ctrl: sequences host write/search/read/clear commands onto one
// CAM word, samples the cells and returns a verified response.
module cam_word_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             cell_reset_o,
  output logic [WIDTH-1:0] cell_data_o,
  output logic             cell_write_enable_o,
  output logic             cell_search_enable_o,
  output logic [WIDTH-1:0] cell_search_o,
  input  logic [WIDTH-1:0] cell_data_i,
  input  logic [WIDTH-1:0] cell_match_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [1:0]       rsp_op_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [WIDTH-1:0] rsp_match_o,
  output logic             rsp_hit_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] hit_count_o
);

  typedef enum logic [1:0] {
    IDLE, DRIVE, CAPTURE, RESP
  } state_t;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_SR = 2'b01;
  localparam logic [1:0] OP_CL = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             crst_q, crst_d;
  logic [WIDTH-1:0] cdata_q, cdata_d;
  logic             cwe_q, cwe_d;
  logic             cse_q, cse_d;
  logic [WIDTH-1:0] csrch_q, csrch_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] rmatch_q, rmatch_d;
  logic             rhit_q, rhit_d;
  logic             rerr_q, rerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit = &cell_match_i;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    crst_d   = 1'b0;
    cdata_d  = '0;
    cwe_d    = 1'b0;
    cse_d    = 1'b0;
    csrch_d  = '0;
    rdata_d  = rdata_q;
    rmatch_d = rmatch_q;
    rhit_d   = rhit_q;
    rerr_d   = rerr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          state_d = DRIVE;
          op_d    = cmd_op_i;
          data_d  = cmd_data_i;
          // Cell strobes are registered so they appear only during DRIVE
          unique case (cmd_op_i)
            OP_WR: begin
              cwe_d   = 1'b1;
              cdata_d = cmd_data_i;
            end
            OP_SR: begin
              cse_d   = 1'b1;
              csrch_d = cmd_data_i;
            end
            OP_CL: crst_d = 1'b1;
            default: ;
          endcase
        end
      end
      DRIVE: state_d = CAPTURE;
      CAPTURE: begin
        state_d  = RESP;
        rdata_d  = cell_data_i;
        rmatch_d = '0;
        rhit_d   = 1'b0;
        rerr_d   = 1'b0;
        unique case (op_q)
          OP_WR: rerr_d = (cell_data_i != data_q);
          OP_CL: rerr_d = (cell_data_i != '0);
          OP_SR: begin
            rmatch_d = cell_match_i;
            rhit_d   = hit;
            if (hit && (cnt_q != {CNT_W{1'b1}}))
              cnt_d = cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      crst_q   <= 1'b0;
      cdata_q  <= '0;
      cwe_q    <= 1'b0;
      cse_q    <= 1'b0;
      csrch_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rmatch_q <= '0;
      rhit_q   <= 1'b0;
      rerr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      crst_q   <= crst_d;
      cdata_q  <= cdata_d;
      cwe_q    <= cwe_d;
      cse_q    <= cse_d;
      csrch_q  <= csrch_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rmatch_q <= rmatch_d;
      rhit_q   <= rhit_d;
      rerr_q   <= rerr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cmd_ready_o          = ready_q;
  assign cell_reset_o         = crst_q;
  assign cell_data_o          = cdata_q;
  assign cell_write_enable_o  = cwe_q;
  assign cell_search_enable_o = cse_q;
  assign cell_search_o        = csrch_q;
  assign rsp_valid_o          = rvalid_q;
  assign rsp_op_o             = op_q;
  assign rsp_data_o           = rdata_q;
  assign rsp_match_o          = rmatch_q;
  assign rsp_hit_o            = rhit_q;
  assign rsp_err_o            = rerr_q;
  assign hit_count_o          = cnt_q;

endmodule

// File: doc/cam_word_ctrl.md
# cam_word_ctrl

Command-driven controller for one CAM word built from `WIDTH` flip-flop CAM cells. It sits between a host command stream and the cell array. It sequences write, search, read and clear operations onto the cell-side signals (`reset`, `data_i`, `write_enable_i`, `search_enable_i`, `search_i`), then samples the cell outputs (`data_o`, `match_o`). Each command produces exactly one response, returned over a valid/ready channel; writes and clears are read back and verified.

## Interface
- `WIDTH`, default 8: number of CAM cells in the word.
- `CNT_W`, default 16: width of the saturating hit counter.

- `clk`  in  1  clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  host command valid.
- `cmd_ready_o`  out  1  controller accepts a command.
- `cmd_op_i`  in  2  operation code: 00 write, 01 search, 10 read, 11 clear.
- `cmd_data_i`  in  WIDTH  write data, or search key.
- `cell_reset_o`  out  1  reset to all cells.
- `cell_data_o`  out  WIDTH  per-cell `data_i`.
- `cell_write_enable_o`  out  1  shared `write_enable_i`.
- `cell_search_enable_o`  out  1  shared `search_enable_i`.
- `cell_search_o`  out  WIDTH  per-cell `search_i`.
- `cell_data_i`  in  WIDTH  per-cell stored bit (`data_o`).
- `cell_match_i`  in  WIDTH  per-cell `match_o`; registered in the cell, valid the cycle after search enable.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  host accepts the response.
- `rsp_op_o`  out  2  echoed opcode.
- `rsp_data_o`  out  WIDTH  sampled `cell_data_i`.
- `rsp_match_o`  out  WIDTH  sampled `cell_match_i`; all zeros for non-search operations.
- `rsp_hit_o`  out  1  search hit, defined as AND of all `cell_match_i` bits.
- `rsp_err_o`  out  1  readback mismatch on write or clear.
- `hit_count_o`  out  CNT_W  saturating count of search hits.

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, RESP.
- **IDLE**
  - `cmd_ready_o` = 1 and all cell outputs are 0.
  - A handshake (`cmd_valid_i && cmd_ready_o`) latches the opcode and data, then moves to DRIVE.
- **DRIVE** lasts exactly one cycle and asserts only the signals for the latched opcode:
  - write: `cell_write_enable_o` = 1, `cell_data_o` = data.
  - search: `cell_search_enable_o` = 1, `cell_search_o` = key.
  - clear: `cell_reset_o` = 1.
  - read: no cell signal asserted.
  - The FSM then moves to CAPTURE.
- **CAPTURE** lasts one cycle. All cell outputs are 0 again. At the end of the cycle the block registers:
  - `rsp_data_o` ← `cell_data_i`.
  - For search only: `rsp_match_o` ← `cell_match_i` and `rsp_hit_o` ← &`cell_match_i`.
  - `rsp_err_o` ← (`cell_data_i` != data) for write; (`cell_data_i` != 0) for clear; 0 otherwise.
  - `hit_count_o` increments on a search hit, saturating at 2^CNT_W−1.
  - The FSM then moves to RESP.
- **RESP**
  - `rsp_valid_o` = 1, with all `rsp_*` outputs held stable until `rsp_ready_i`.
  - On the edge where `rsp_ready_i` = 1, the FSM moves to IDLE.
- Only one command is in flight at a time. A `cmd_valid_i` outside IDLE is ignored because `cmd_ready_o` = 0.
- `hit_count_o` is cleared only by `reset`. The clear opcode does not clear it.

## Timing
- Reset values: state IDLE, and every output 0, including `cmd_ready_o` and `hit_count_o`.
  - `cmd_ready_o` rises in the first cycle after `reset` deasserts.
- Command accepted at edge N:
  - DRIVE occupies cycle N..N+1.
  - CAPTURE occupies cycle N+1..N+2.
  - `rsp_valid_o` is high from edge N+2.
  - Latency from accept to response valid is 2 edges.
- If `rsp_ready_i` is already 1 when the response appears:
  - The response is taken at edge N+3.
  - `cmd_ready_o` is high in the following cycle.
  - Peak throughput is one command per 4 cycles.
- Enables (`cell_write_enable_o`, `cell_search_enable_o`, `cell_reset_o`) are registered outputs and are never high for more than one cycle per command.
- Reset asserted mid-operation, in any state, with the synchronous edge: the command is abandoned and no response is issued.
  - Any enable pulse in progress ends at that edge.
- Holding `rsp_ready_i` low stalls the FSM in RESP indefinitely, with no loss of data.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `cmd_valid_i` = 1.
  - All outputs must be 0 and no command accepted.
  - `cmd_ready_o` = 1 one cycle after release.
- **Write then read, WIDTH=8:** write 8'hA5, then read.
  - Write response: `rsp_data_o` = A5, `rsp_err_o` = 0, `cell_write_enable_o` high for exactly 1 cycle.
  - Read response: `rsp_data_o` = A5.
- **Search hit and miss** on stored A5.
  - Search key A5 → `rsp_hit_o` = 1, `rsp_match_o` = FF, `hit_count_o` = 1.
  - Search key A4 → `rsp_hit_o` = 0, `rsp_match_o` = FE, count stays 1.
- **Clear and error:**
  - Clear → `cell_reset_o` pulses 1 cycle, `rsp_data_o` = 00, `rsp_err_o` = 0.
  - Force a stuck cell bit 0 at 1 → `rsp_err_o` = 1.
- **Backpressure:** hold `rsp_ready_i` = 0 for 10 cycles.
  - Response stays stable, `cmd_ready_o` stays 0 and a second command is not accepted.
  - Release → exactly one handshake, then IDLE.
- **Reset during DRIVE of a search:**
  - `cell_search_enable_o` drops at the reset edge.
  - No `rsp_valid_o` and `hit_count_o` = 0.
  - Counter saturation is checked separately with CNT_W = 2: 5 hits → `hit_count_o` = 3.
